// File: rtl/mmio_button_hub_if.sv
// rtl/mmio_button_hub_if.sv - data-memory bus bundle between the processor wrapper and the button hub
// Purpose: groups the dmem-side load/store signals seen by mmio_button_hub.
// Signals:
//   addr[11:0]     word address (address_dmem[11:0])
//   wren           store strobe
//   rden           load strobe (memory stage)
//   data_in[31:0]  store data
//   q[31:0]        read data, combinational, 0 when not hit
//   hit            address falls inside the hub's three-register window
// Modports: master (processor/wrapper side), slave (peripheral side).
interface mmio_button_hub_if;
  logic [11:0] addr;
  logic        wren;
  logic        rden;
  logic [31:0] data_in;
  logic [31:0] q;
  logic        hit;

  modport master (output addr, wren, rden, data_in, input q, hit);
  modport slave  (input addr, wren, rden, data_in, output q, hit);
endinterface

// File: rtl/mmio_button_hub.sv
// rtl/mmio_button_hub.sv - debounced button event FIFO and LED driver on the processor dmem bus
// Purpose: per-channel synchroniser + debouncer, press events queued in a FIFO
//   drained by EVENT reads, STATUS register, LEDCTL steady/flash LED control.
// Optional: define TIMESTAMP_EN to tag each event with a 16-bit timestamp
//   (one tick every 1024 cycles) returned in EVENT[23:8].
// Ports:
//   clock          system clock
//   reset          asynchronous active-high reset
//   buttons[N-1:0] raw button inputs, 1 = pressed
//   bus            mmio_button_hub_if.slave (addr/wren/rden/data_in in, q/hit out)
//   leds[N-1:0]    LED drive, 1 = on
//   irq            registered, high while the event FIFO is non-empty
module mmio_button_hub #(
  parameter int          NUM_CH          = 4,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          FLASH_CYCLES    = 12500000,
  parameter logic [11:0] BASE_ADDR       = 12'd7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] buttons,
  mmio_button_hub_if.slave  bus,
  output logic [NUM_CH-1:0] leds,
  output logic              irq
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FLASH_CYCLES + 1);
`ifdef TIMESTAMP_EN
  localparam int EW = 24;
`else
  localparam int EW = 8;
`endif
  localparam logic [11:0] EVENT_ADDR  = BASE_ADDR;
  localparam logic [11:0] STATUS_ADDR = BASE_ADDR + 12'd1;
  localparam logic [11:0] LEDCTL_ADDR = BASE_ADDR + 12'd2;
  localparam logic [AW:0] FULL_CNT    = FIFO_DEPTH[AW:0];

  logic [NUM_CH-1:0] r_sync1, r_sync2, r_level, w_level_nxt;
  logic [DW-1:0]     r_db_cnt [NUM_CH];
  logic [DW-1:0]     w_db_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_pending, w_grant;
  logic [7:0]        w_push_ch;
  logic              w_found;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [EW-1:0]     w_entry, w_head;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow, r_ev_match_d, r_st_match_d, r_irq;
  logic              w_ev_match, w_st_match, w_pop, w_push, w_push_req, w_full, w_ovf_set, w_st_clr;
  logic              w_led_wr;
  logic [NUM_CH-1:0] r_leds;
  logic [FW-1:0]     r_flash_cnt [NUM_CH];
  logic [31:0]       w_q;
  wire               w_unused = &{1'b0, bus.data_in[31:10], bus.data_in[7:5]};

  // Debounce: count consecutive disagreeing cycles; toggle on the cycle the
  // count would reach DEBOUNCE_CYCLES.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_level_nxt[i]  = r_level[i];
      w_db_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_level[i]) begin
        if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) w_level_nxt[i] = ~r_level[i];
        else w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_pending <= '0;
      for (int i = 0; i < NUM_CH; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= buttons;
      r_sync2   <= r_sync1;
      r_level   <= w_level_nxt;
      // Grant clears the old pending bit; a fresh press sets it on the same edge.
      r_pending <= (r_pending & ~w_grant) | (w_level_nxt & ~r_level);
      for (int i = 0; i < NUM_CH; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
    end
  end

  // Fixed-priority arbiter: lowest pending channel wins.
  always_comb begin
    w_grant   = '0;
    w_push_ch = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && r_pending[i]) begin
        w_grant[i] = 1'b1;
        w_push_ch  = 8'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Reads pop/clear only on the first cycle of a held match.
  assign w_ev_match = bus.rden && (bus.addr == EVENT_ADDR);
  assign w_st_match = bus.rden && (bus.addr == STATUS_ADDR);
  assign w_st_clr   = w_st_match && !r_st_match_d;
  assign w_pop      = w_ev_match && !r_ev_match_d && (r_count != '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_push_req = |r_pending;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_head     = r_mem[r_rd_ptr];

`ifdef TIMESTAMP_EN
  logic [9:0]  r_prescale;
  logic [15:0] r_ts;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
      r_ts       <= '0;
    end else begin
      r_prescale <= r_prescale + 10'd1;
      if (r_prescale == 10'h3FF) r_ts <= r_ts + 16'd1;
    end
  end
  assign w_entry = {r_ts, w_push_ch};
`else
  assign w_entry = w_push_ch;
`endif

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_ev_match_d <= 1'b0;
      r_st_match_d <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_ev_match_d <= w_ev_match;
      r_st_match_d <= w_st_match;
      r_irq        <= (r_count != '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // A new overflow on the clearing edge wins.
      if (w_ovf_set)     r_overflow <= 1'b1;
      else if (w_st_clr) r_overflow <= 1'b0;
    end
  end

  // LED control: steady writes cancel any running flash timer.
  assign w_led_wr = bus.wren && (bus.addr == LEDCTL_ADDR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_leds <= '0;
      for (int i = 0; i < NUM_CH; i++) r_flash_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_led_wr && (bus.data_in[4:0] == 5'(i))) begin
          if (bus.data_in[9]) begin
            r_leds[i]      <= 1'b1;
            r_flash_cnt[i] <= FW'(FLASH_CYCLES);
          end else begin
            r_leds[i]      <= bus.data_in[8];
            r_flash_cnt[i] <= '0;
          end
        end else if (r_flash_cnt[i] != '0) begin
          r_flash_cnt[i] <= r_flash_cnt[i] - 1'b1;
          if (r_flash_cnt[i] == FW'(1)) r_leds[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_q = '0;
    if (bus.addr == EVENT_ADDR) begin
      if (r_count != '0) begin
        w_q[31]  = 1'b1;
        w_q[7:0] = w_head[7:0];
`ifdef TIMESTAMP_EN
        w_q[23:8] = w_head[23:8];
`endif
      end
    end else if (bus.addr == STATUS_ADDR) begin
      w_q[AW:0]          = r_count;
      w_q[8]             = r_overflow;
      w_q[16 +: NUM_CH]  = r_level;
    end else if (bus.addr == LEDCTL_ADDR) begin
      w_q[NUM_CH-1:0] = r_leds;
    end
  end

  assign bus.q   = w_q;
  assign bus.hit = (bus.addr >= EVENT_ADDR) && (bus.addr <= LEDCTL_ADDR);
  assign leds    = r_leds;
  assign irq     = r_irq;
endmodule
